inv_sub_bytes_seq: RTL and testbench



---
 rtl/inv_sub_bytes_seq.sv | 119 +++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Time-multiplexed AES InvSubBytes: LANES inverse S-boxes walk a captured
// 128-bit state over N = 16/LANES cycles, then publish it with a one-cycle strobe.
module inv_sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] in_data,
  input  logic         in_ready,
  output logic [0:127] out_data,
  output logic         out_ready,
  output logic         busy,
  output logic         overrun
);

  localparam int unsigned N  = 16 / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // FIPS-197 inverse S-box; entry v occupies bits [8v:8v+7].
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [0:127]    buf_q, buf_d;
  logic [0:127]    out_q, out_d;
  logic            out_ready_q, out_ready_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  logic [0:127]    sub_buf;
  logic [3:0]      base;
  logic [3:0]      idx;

  // Chunk base is a multiple of LANES taken mod 16, so base+lane never passes byte 15.
  always_comb begin
    sub_buf = buf_q;
    base    = 4'((32'(cnt_q) * LANES) % 16);
    idx     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      idx = base + 4'(l);
      sub_buf[{idx, 3'b000} +: 8] = inv_sbox(buf_q[{idx, 3'b000} +: 8]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_d       = out_q;
    out_ready_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (in_ready) begin
          buf_d   = in_data;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        buf_d = sub_buf;
        if (in_ready) overrun_d = 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          out_d       = sub_buf;
          out_ready_d = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      out_q       <= '0;
      out_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_q       <= out_d;
      out_ready_q <= out_ready_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_q;
  assign out_ready = out_ready_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq at LANES = 1, 4 and 16 sharing one stimulus;
// the byte reference is derived from GF(2^8) inversion plus the AES affine map.
module tb_inv_sub_bytes_seq;

  logic         clk;
  logic         reset;
  logic [0:127] in_data;
  logic         in_ready;

  logic [0:127] od1, od4, od16;
  logic         or1, or4, or16;
  logic         bz1, bz4, bz16;
  logic         ov1, ov4, ov16;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  localparam logic [0:127] D = 128'h637C_0016_ED63_7C00_16ED_637C_0016_ED63;
  localparam logic [0:127] E = 128'h0001_52FF_5300_0152_FF53_0001_52FF_5300;

  inv_sub_bytes_seq #(.LANES(1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ready(in_ready),
    .out_data(od1), .out_ready(or1), .busy(bz1), .overrun(ov1));
  inv_sub_bytes_seq #(.LANES(4)) u4 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ready(in_ready),
    .out_data(od4), .out_ready(or4), .busy(bz4), .overrun(ov4));
  inv_sub_bytes_seq #(.LANES(16)) u16 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ready(in_ready),
    .out_data(od16), .out_ready(or16), .busy(bz16), .overrun(ov16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_ready = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_model();
    logic [7:0] xi, r, s;
    for (int x = 0; x < 256; x++) begin
      xi = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
      s = xi;
      r = xi;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s ^= r;
      end
      s ^= 8'h63;
      fwd_m[x] = s;
      inv_m[s] = 8'(x);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_ready = 1'b0;
    in_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (od4 !== '0 || or4 !== 1'b0 || bz4 !== 1'b0 || ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u4 got od=%h rdy=%b busy=%b ovr=%b want all zero", od4, or4, bz4, ov4);
    end
    n_checks++;
    if (od1 !== '0 || or1 !== 1'b0 || bz1 !== 1'b0 || ov1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u1 got od=%h rdy=%b busy=%b ovr=%b want all zero", od1, or1, bz1, ov1);
    end
    n_checks++;
    if (od16 !== '0 || or16 !== 1'b0 || bz16 !== 1'b0 || ov16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u16 got od=%h rdy=%b busy=%b ovr=%b want all zero", od16, or16, bz16, ov16);
    end
  endtask

  task automatic test_latency();
    do_reset();
    in_data  = D;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      n_checks++;
      if (or4 !== (c == 5) || bz4 !== (c >= 1 && c <= 4)) begin
        n_fail++;
        $display("FAIL lat_u4 cycle %0d got rdy=%b busy=%b want rdy=%b busy=%b",
                 c, or4, bz4, (c == 5), (c >= 1 && c <= 4));
      end
      n_checks++;
      if (or1 !== (c == 17) || bz1 !== (c <= 16)) begin
        n_fail++;
        $display("FAIL lat_u1 cycle %0d got rdy=%b busy=%b want rdy=%b busy=%b",
                 c, or1, bz1, (c == 17), (c <= 16));
      end
      n_checks++;
      if (or16 !== (c == 2) || bz16 !== (c == 1)) begin
        n_fail++;
        $display("FAIL lat_u16 cycle %0d got rdy=%b busy=%b want rdy=%b busy=%b",
                 c, or16, bz16, (c == 2), (c == 1));
      end
      n_checks++;
      if (od4 !== ((c >= 5) ? E : '0)) begin
        n_fail++;
        $display("FAIL lat_u4_data cycle %0d got %h want %h", c, od4, ((c >= 5) ? E : '0));
      end
      if (c == 17) begin
        n_checks++;
        if (od1 !== E) begin
          n_fail++;
          $display("FAIL lat_u1_data got %h want %h", od1, E);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (od16 !== E) begin
          n_fail++;
          $display("FAIL lat_u16_data got %h want %h", od16, E);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_data  = {16{8'h63}};
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        in_data  = {16{8'h7C}};
        in_ready = 1'b1;
      end
      n_checks++;
      if (or4 !== (c == 5 || c == 10)) begin
        n_fail++;
        $display("FAIL b2b_ready cycle %0d got %b want %b", c, or4, (c == 5 || c == 10));
      end
      if (c == 5 || c == 10) begin
        n_checks++;
        if (od4 !== ((c == 5) ? {16{8'h00}} : {16{8'h01}})) begin
          n_fail++;
          $display("FAIL b2b_data cycle %0d got %h want %h", c, od4,
                   ((c == 5) ? {16{8'h00}} : {16{8'h01}}));
        end
      end
      n_checks++;
      if (ov4 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_overrun cycle %0d got %b want 0", c, ov4);
      end
      tick();
      in_ready = 1'b0;
    end
  endtask

  task automatic test_overrun();
    do_reset();
    in_data  = D;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    tick();
    in_data  = {16{8'h00}};
    in_ready = 1'b1;
    n_checks++;
    if (ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_before got %b want 0", ov4);
    end
    tick();
    in_ready = 1'b0;
    for (int c = 3; c <= 12; c++) begin
      n_checks++;
      if (ov4 !== 1'b1 || or4 !== (c == 5)) begin
        n_fail++;
        $display("FAIL ovr_cycle %0d got ovr=%b rdy=%b want ovr=1 rdy=%b", c, ov4, or4, (c == 5));
      end
      if (c == 5) begin
        n_checks++;
        if (od4 !== E) begin
          n_fail++;
          $display("FAIL ovr_data got %h want %h", od4, E);
        end
      end
      tick();
    end
    do_reset();
    n_checks++;
    if (ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_cleared got %b want 0", ov4);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    in_data  = D;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    for (int c = 1; c <= 18; c++) tick();
    n_checks++;
    if (od4 !== E) begin
      n_fail++;
      $display("FAIL mid_pre_data got %h want %h", od4, E);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    tick();
    reset    = 1'b1;
    in_data  = {16{8'h16}};
    in_ready = 1'b1;
    tick();
    reset    = 1'b0;
    in_ready = 1'b0;
    n_checks++;
    if (bz4 !== 1'b0 || or4 !== 1'b0 || od4 !== '0 || ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after_reset got busy=%b rdy=%b od=%h ovr=%b want 0 0 0 0", bz4, or4, od4, ov4);
    end
    n_checks++;
    if (bz1 !== 1'b0 || od1 !== '0 || bz16 !== 1'b0 || od16 !== '0) begin
      n_fail++;
      $display("FAIL mid_after_reset_other got busy1=%b od1=%h busy16=%b od16=%h want zeros",
               bz1, od1, bz16, od16);
    end
    tick();
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    for (int c = 5; c <= 10; c++) begin
      n_checks++;
      if (or4 !== (c == 9)) begin
        n_fail++;
        $display("FAIL mid_fresh_ready cycle %0d got %b want %b", c, or4, (c == 9));
      end
      if (c == 9) begin
        n_checks++;
        if (od4 !== {16{8'hFF}}) begin
          n_fail++;
          $display("FAIL mid_fresh_data got %h want %h", od4, {16{8'hFF}});
        end
      end
      tick();
    end
  endtask

  task automatic test_exhaustive();
    logic [0:127] blk;
    logic [7:0]   ib, o1, o4, o16;
    do_reset();
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(16 * b + k);
      in_data  = blk;
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      for (int c = 1; c <= 17; c++) tick();
      for (int k = 0; k < 16; k++) begin
        ib  = blk[8*k +: 8];
        o1  = od1[8*k +: 8];
        o4  = od4[8*k +: 8];
        o16 = od16[8*k +: 8];
        n_checks++;
        if (o1 !== inv_m[ib] || o4 !== inv_m[ib] || o16 !== inv_m[ib]) begin
          n_fail++;
          $display("FAIL exh_inv byte %h got l1=%h l4=%h l16=%h want %h", ib, o1, o4, o16, inv_m[ib]);
        end
        n_checks++;
        if (fwd_m[o4] !== ib) begin
          n_fail++;
          $display("FAIL exh_roundtrip byte %h got %h want %h", ib, fwd_m[o4], ib);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in_ready = 1'b0;
    in_data  = '0;
    build_model();
    test_reset();
    test_latency();
    test_back_to_back();
    test_overrun();
    test_reset_mid_run();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
